bfly12_round_sat: RTL and testbench



---
 rtl/bfly12_round_sat_if.sv | 34 +++
 rtl/bfly12_round_sat.sv | 135 +++++++++++++
 tb/tb_bfly12_round_sat.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bfly12_round_sat_if.sv
// Group bus between the twiddle multiplier and the round/saturate stage.
// Raw products go in; rounded samples and block statistics come out.
interface bfly12_round_sat_if #(
    parameter int N       = 8,
    parameter int IN_BIT  = 25,
    parameter int OUT_BIT = 16
);
    logic                      din_valid;
    logic signed [IN_BIT-1:0]  din1_i [0:N-1];
    logic signed [IN_BIT-1:0]  din1_q [0:N-1];
    logic signed [IN_BIT-1:0]  din2_i [0:N-1];
    logic signed [IN_BIT-1:0]  din2_q [0:N-1];
    logic                      dout_valid;
    logic signed [OUT_BIT-1:0] dout1_i [0:N-1];
    logic signed [OUT_BIT-1:0] dout1_q [0:N-1];
    logic signed [OUT_BIT-1:0] dout2_i [0:N-1];
    logic signed [OUT_BIT-1:0] dout2_q [0:N-1];
    logic                      blk_start;
    logic                      blk_last;
    logic [9:0]                blk_sat_cnt;
    logic                      sat_flag;

    modport master (
        output din_valid, din1_i, din1_q, din2_i, din2_q,
        input  dout_valid, dout1_i, dout1_q, dout2_i, dout2_q,
        input  blk_start, blk_last, blk_sat_cnt, sat_flag
    );

    modport slave (
        input  din_valid, din1_i, din1_q, din2_i, din2_q,
        output dout_valid, dout1_i, dout1_q, dout2_i, dout2_q,
        output blk_start, blk_last, blk_sat_cnt, sat_flag
    );
endinterface

// File: rtl/bfly12_round_sat.sv
// Round-and-saturate stage after the butterfly twiddle multiply, with
// per-block framing and saturation statistics. Two register stages.
module bfly12_round_sat #(
    parameter int N       = 8,
    parameter int IN_BIT  = 25,
    parameter int OUT_BIT = 16,
    parameter int FRAC    = 7,
    parameter int BLK_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    bfly12_round_sat_if.slave io
);
    localparam int RW = IN_BIT + 1 - FRAC;
    localparam int CW = $clog2(BLK_CYC);
    localparam int PW = $clog2(4 * N + 1);
    localparam logic [CW-1:0] LASTC = CW'(BLK_CYC - 1);
    localparam logic signed [RW-1:0] SMAX =
        RW'((1 << (OUT_BIT - 1)) - 1);
    localparam logic signed [RW-1:0] SMIN = ~SMAX;

    // Add one bit of headroom so the largest positive input cannot wrap.
    function automatic logic signed [RW-1:0] rnd(
        input logic signed [IN_BIT-1:0] v
    );
        logic signed [IN_BIT:0] s;
        s = {v[IN_BIT-1], v}
          + {{(IN_BIT+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
        return s[IN_BIT:FRAC];
    endfunction

    logic signed [IN_BIT-1:0]  x   [4][N];
    logic signed [RW-1:0]      r_d [4][N];
    logic signed [RW-1:0]      r_q [4][N];
    logic signed [OUT_BIT-1:0] y_d [4][N];
    logic signed [OUT_BIT-1:0] y_q [4][N];
    logic [PW-1:0] pop;
    logic          v1_q, v2_q;
    logic          start_d, start_q, last_d, last_q;
    logic [CW-1:0] cyc_d, cyc_q;
    logic [9:0]    run_d, run_q, cnt_d, cnt_q;
    logic          flag_d, flag_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x[0][i] = io.din1_i[i];
            x[1][i] = io.din1_q[i];
            x[2][i] = io.din2_i[i];
            x[3][i] = io.din2_q[i];
        end
    end

    always_comb begin
        pop = '0;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < N; i++) begin
                r_d[g][i] = rnd(x[g][i]);
                if (r_q[g][i] > SMAX) begin
                    y_d[g][i] = {1'b0, {(OUT_BIT-1){1'b1}}};
                    pop = pop + 1'b1;
                end else if (r_q[g][i] < SMIN) begin
                    y_d[g][i] = {1'b1, {(OUT_BIT-1){1'b0}}};
                    pop = pop + 1'b1;
                end else begin
                    y_d[g][i] = r_q[g][i][OUT_BIT-1:0];
                end
            end
        end
    end

    // Framing and statistics advance only on groups entering stage 2.
    always_comb begin
        cyc_d   = cyc_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        start_d = v1_q && (cyc_q == '0);
        last_d  = v1_q && (cyc_q == LASTC);
        if (v1_q) begin
            cyc_d = last_d ? '0 : cyc_q + 1'b1;
            if (last_d) begin
                cnt_d = run_q + 10'(pop);
                run_d = '0;
            end else begin
                run_d = run_q + 10'(pop);
            end
            if (pop != '0) flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 4; g++) begin
                for (int i = 0; i < N; i++) begin
                    r_q[g][i] <= '0;
                    y_q[g][i] <= '0;
                end
            end
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            cyc_q   <= '0;
            run_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            r_q     <= r_d;
            y_q     <= y_d;
            v1_q    <= io.din_valid;
            v2_q    <= v1_q;
            start_q <= start_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            io.dout1_i[i] = y_q[0][i];
            io.dout1_q[i] = y_q[1][i];
            io.dout2_i[i] = y_q[2][i];
            io.dout2_q[i] = y_q[3][i];
        end
    end

    assign io.dout_valid  = v2_q;
    assign io.blk_start   = start_q;
    assign io.blk_last    = last_q;
    assign io.blk_sat_cnt = cnt_q;
    assign io.sat_flag    = flag_q;
endmodule

// File: tb/tb_bfly12_round_sat.sv
// Testbench for bfly12_round_sat: directed vector table, framing and
// statistics sequences, and a free-running arithmetic reference model.
module tb_bfly12_round_sat;
    localparam int N = 8;
    localparam int IN_BIT = 25;
    localparam int OUT_BIT = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    bfly12_round_sat_if #(.N(N), .IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT)) bus ();

    bfly12_round_sat #(.N(N), .IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT),
                       .FRAC(7), .BLK_CYC(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: floor((x + 64) / 128), then clamp to 16-bit signed.
    function automatic int ref_rs(input int x, output bit s);
        longint t;
        longint q;
        t = longint'(x) + 64;
        q = (t >= 0) ? t / 128 : -((-t + 127) / 128);
        s = 1'b0;
        if (q > 32767) begin
            s = 1'b1;
            return 32767;
        end
        if (q < -32768) begin
            s = 1'b1;
            return -32768;
        end
        return int'(q);
    endfunction

    function automatic int outv(input int g, input int i);
        case (g)
            0: return int'(bus.dout1_i[i]);
            1: return int'(bus.dout1_q[i]);
            2: return int'(bus.dout2_i[i]);
            default: return int'(bus.dout2_q[i]);
        endcase
    endfunction

    task automatic set_lane(input int g, input int i, input int v);
        case (g)
            0: bus.din1_i[i] = 25'(v);
            1: bus.din1_q[i] = 25'(v);
            2: bus.din2_i[i] = 25'(v);
            default: bus.din2_q[i] = 25'(v);
        endcase
    endtask

    typedef struct {
        bit v;
        int d[4][N];
    } snap_t;

    snap_t cur, last_s, prev_s;

    // Input history: what the DUT sampled on the last two edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last_s.v = 1'b0;
            prev_s.v = 1'b0;
        end else begin
            cur.v = bus.din_valid;
            for (int i = 0; i < N; i++) begin
                cur.d[0][i] = int'(bus.din1_i[i]);
                cur.d[1][i] = int'(bus.din1_q[i]);
                cur.d[2][i] = int'(bus.din2_i[i]);
                cur.d[3][i] = int'(bus.din2_q[i]);
            end
            prev_s = last_s;
            last_s = cur;
        end
    end

    int mcyc, mrun, mcnt;
    bit mflag;

    always @(negedge clk) begin
        if (rst) begin
            mcyc = 0;
            mrun = 0;
            mcnt = 0;
            mflag = 1'b0;
        end else begin
            chk("dout_valid", int'(bus.dout_valid), int'(prev_s.v));
            if (prev_s.v) begin
                int ns;
                ns = 0;
                for (int g = 0; g < 4; g++) begin
                    for (int i = 0; i < N; i++) begin
                        bit s;
                        int e;
                        e = ref_rs(prev_s.d[g][i], s);
                        chk($sformatf("lane g%0d i%0d", g, i),
                            outv(g, i), e);
                        ns += int'(s);
                    end
                end
                chk("blk_start", int'(bus.blk_start), int'(mcyc == 0));
                chk("blk_last", int'(bus.blk_last), int'(mcyc == 31));
                mrun += ns;
                if (mcyc == 31) begin
                    mcnt = mrun;
                    mrun = 0;
                end
                if (ns > 0) mflag = 1'b1;
                mcyc = (mcyc + 1) % 32;
            end else begin
                chk("blk_start idle", int'(bus.blk_start), 0);
                chk("blk_last idle", int'(bus.blk_last), 0);
            end
            chk("blk_sat_cnt", int'(bus.blk_sat_cnt), mcnt);
            chk("sat_flag", int'(bus.sat_flag), int'(mflag));
        end
    end

    task automatic clear_in();
        for (int g = 0; g < 4; g++)
            for (int i = 0; i < N; i++) set_lane(g, i, 0);
    endtask

    // mode 0: in-range data, 1: full 25-bit range, 2: three saturating lanes
    task automatic fill(input int mode);
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < N; i++) begin
                int v;
                if (mode == 1) v = $signed($urandom) >>> 7;
                else v = int'($urandom_range(0, 8388000)) - 4194000;
                set_lane(g, i, v);
            end
        end
        if (mode == 2) begin
            set_lane(0, 0, (1 << 24) - 1);
            set_lane(1, 3, -(1 << 24));
            set_lane(3, 7, 1 << 22);
        end
    endtask

    task automatic run_valids(input int n, input int gap_every,
                              input int gap_len, input int mode,
                              input int nsat);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            fill((k < nsat) ? mode : 0);
            bus.din_valid = 1'b1;
            if (gap_every > 0 && (k + 1) % gap_every == 0 && k != n - 1) begin
                for (int j = 0; j < gap_len; j++) begin
                    @(posedge clk);
                    #1;
                    bus.din_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dout_valid"}, int'(bus.dout_valid), 0);
        chk({tag, " blk_start"}, int'(bus.blk_start), 0);
        chk({tag, " blk_last"}, int'(bus.blk_last), 0);
        chk({tag, " blk_sat_cnt"}, int'(bus.blk_sat_cnt), 0);
        chk({tag, " sat_flag"}, int'(bus.sat_flag), 0);
        chk({tag, " dout1_i0"}, int'(bus.dout1_i[0]), 0);
        chk({tag, " dout2_q7"}, int'(bus.dout2_q[N-1]), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int g;
        int i;
        int x;
        int exp;
        bit sat;
    } vec_t;

    vec_t tv[14];
    bit   seen_sat;
    int   cnt0, flag0;

    initial begin
        n_chk = 0;
        n_fail = 0;
        tv[0]  = '{0, 0, 128, 1, 0};
        tv[1]  = '{1, 0, 191, 1, 0};
        tv[2]  = '{2, 0, 192, 2, 0};
        tv[3]  = '{3, 0, -192, -1, 0};
        tv[4]  = '{0, 0, 63, 0, 0};
        tv[5]  = '{0, 0, 64, 1, 0};
        tv[6]  = '{0, 0, -64, 0, 0};
        tv[7]  = '{1, 5, -65, -1, 0};
        tv[8]  = '{0, 0, 32767 * 128, 32767, 0};
        tv[9]  = '{2, 3, -32768 * 128, -32768, 0};
        tv[10] = '{0, 0, 1 << 22, 32767, 1};
        tv[11] = '{0, 0, -(1 << 23), -32768, 1};
        tv[12] = '{3, 7, (1 << 24) - 1, 32767, 1};
        tv[13] = '{1, 2, -(1 << 24), -32768, 1};

        rst = 1'b1;
        bus.din_valid = 1'b0;
        clear_in();
        #1;
        chk_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        seen_sat = 1'b0;
        foreach (tv[k]) begin
            @(posedge clk);
            #1;
            clear_in();
            set_lane(tv[k].g, tv[k].i, tv[k].x);
            bus.din_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.din_valid = 1'b0;
            clear_in();
            @(posedge clk);
            @(negedge clk);
            if (tv[k].sat) seen_sat = 1'b1;
            chk($sformatf("vec%0d valid", k), int'(bus.dout_valid), 1);
            chk($sformatf("vec%0d value", k),
                outv(tv[k].g, tv[k].i), tv[k].exp);
            chk($sformatf("vec%0d flag", k),
                int'(bus.sat_flag), int'(seen_sat));
        end

        do_reset("rst framing");
        run_valids(64, 0, 0, 0, 0);
        run_valids(64, 5, 3, 0, 0);

        do_reset("rst satcnt");
        run_valids(32, 0, 0, 2, 10);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("block1 sat count", int'(bus.blk_sat_cnt), 30);
        run_valids(32, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("block2 sat count", int'(bus.blk_sat_cnt), 0);
        chk("block2 sat_flag", int'(bus.sat_flag), 1);

        run_valids(5, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        cnt0 = int'(bus.blk_sat_cnt);
        flag0 = int'(bus.sat_flag);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++)
                for (int i = 0; i < N; i++) set_lane(g, i, (1 << 24) - 1);
        end
        @(negedge clk);
        chk("idle sat count", int'(bus.blk_sat_cnt), cnt0);
        chk("idle sat_flag", int'(bus.sat_flag), flag0);
        run_valids(27, 0, 0, 1, 27);
        run_valids(40, 7, 2, 1, 40);

        run_valids(17, 0, 0, 1, 17);
        @(posedge clk);
        #1;
        do_reset("rst mid");
        run_valids(32, 0, 0, 0, 0);
        run_valids(33, 4, 1, 1, 33);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
